// File: rtl/hfrv_console_sink.sv
// Multi-channel memory-mapped console capture with round-robin output stream and sticky exit register.
// Optional macro CONSOLE_SINK_TIMESTAMP_EN adds a per-character push timestamp on char_ts.
module hfrv_console_sink #(
    parameter int          NUM_CH    = 4,
    parameter int          DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'hF00000D0,
    parameter int          DROP_W    = 16,
    localparam int         CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              bus_addr,
    input  logic [31:0]              bus_wdata,
    input  logic [3:0]               bus_we,
    output logic                     char_valid,
    input  logic                     char_ready,
    output logic [7:0]               char_data,
    output logic [CHW-1:0]           char_ch,
`ifdef CONSOLE_SINK_TIMESTAMP_EN
    output logic [31:0]              char_ts,
`endif
    output logic [NUM_CH-1:0]        ch_full,
    output logic [NUM_CH-1:0]        ch_overflow,
    output logic [NUM_CH*DROP_W-1:0] drop_cnt,
    output logic                     halt_valid,
    output logic [31:0]              halt_code,
    output logic                     all_empty
);

    localparam int AW = $clog2(DEPTH);
`ifdef CONSOLE_SINK_TIMESTAMP_EN
    localparam int EW = 40;
`else
    localparam int EW = 8;
`endif

    typedef enum logic {S_IDLE, S_HOLD} state_t;
    state_t state, state_next;

    logic [EW-1:0]     mem [NUM_CH][DEPTH];
    logic [AW:0]       wr_ptr [NUM_CH];
    logic [AW:0]       rd_ptr [NUM_CH];
    logic [CHW-1:0]    rr_ptr;
    logic [NUM_CH-1:0] hit, empty, avail, push, pop, drop;
    logic              store, exit_hit, take, found, load, bypass;
    logic [CHW-1:0]    start, grant;
    logic [EW-1:0]     in_entry, load_entry;
    int                scan_idx;

`ifdef CONSOLE_SINK_TIMESTAMP_EN
    logic [31:0] ts_cnt;
    assign in_entry = {ts_cnt, bus_wdata[7:0]};
`else
    assign in_entry = bus_wdata[7:0];
`endif

    function automatic logic [CHW-1:0] next_ch(input logic [CHW-1:0] c);
        return (int'(c) == NUM_CH - 1) ? '0 : c + 1'b1;
    endfunction

    always_comb begin
        store    = |bus_we;
        exit_hit = store && (bus_addr == BASE_ADDR + 32'(4 * NUM_CH));
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i]     = store && (bus_addr == BASE_ADDR + 32'(4 * i));
            empty[i]   = (wr_ptr[i] == rd_ptr[i]);
            ch_full[i] = ((wr_ptr[i] ^ rd_ptr[i]) == (AW+1)'(DEPTH));
        end
        // A same-cycle store counts as available so an idle sink answers on the next cycle.
        avail = ~empty | hit;
    end

    always_comb begin
        take     = (state == S_IDLE) || char_ready;
        start    = (state == S_IDLE) ? rr_ptr : next_ch(char_ch);
        found    = 1'b0;
        grant    = '0;
        scan_idx = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            scan_idx = (int'(start) + k) % NUM_CH;
            if (!found && avail[scan_idx]) begin
                found = 1'b1;
                grant = CHW'(scan_idx);
            end
        end
        load   = take && found;
        bypass = load && empty[grant];
        pop    = '0;
        if (load && !empty[grant])
            pop[grant] = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            push[i] = hit[i] && !(bypass && (grant == CHW'(i))) && (!ch_full[i] || pop[i]);
            drop[i] = hit[i] && ch_full[i] && !pop[i];
        end
        load_entry = bypass ? in_entry : mem[grant][rd_ptr[grant][AW-1:0]];
        state_next = load ? S_HOLD : (take ? S_IDLE : state);
    end

    assign char_valid = (state == S_HOLD);
    assign all_empty  = (&empty) && !char_valid;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++)
            if (push[i])
                mem[i][wr_ptr[i][AW-1:0]] <= in_entry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            char_data   <= '0;
            char_ch     <= '0;
            ch_overflow <= '0;
            drop_cnt    <= '0;
            halt_valid  <= 1'b0;
            halt_code   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
`ifdef CONSOLE_SINK_TIMESTAMP_EN
            ts_cnt  <= '0;
            char_ts <= '0;
`endif
        end else begin
            state <= state_next;
            if (state == S_HOLD && char_ready)
                rr_ptr <= next_ch(char_ch);
            if (load) begin
                char_data <= load_entry[7:0];
                char_ch   <= grant;
`ifdef CONSOLE_SINK_TIMESTAMP_EN
                char_ts   <= load_entry[39:8];
`endif
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (push[i])
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                if (drop[i]) begin
                    ch_overflow[i] <= 1'b1;
                    if (drop_cnt[i*DROP_W +: DROP_W] != {DROP_W{1'b1}})
                        drop_cnt[i*DROP_W +: DROP_W] <= drop_cnt[i*DROP_W +: DROP_W] + 1'b1;
                end
            end
            if (exit_hit && !halt_valid) begin
                halt_valid <= 1'b1;
                halt_code  <= bus_wdata;
            end
`ifdef CONSOLE_SINK_TIMESTAMP_EN
            ts_cnt <= ts_cnt + 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_hfrv_console_sink.sv
// Self-checking bench for hfrv_console_sink: directed test-plan steps then random traffic,
// all checked every cycle against a queue-based behavioural model.
module tb_hfrv_console_sink;

    localparam int          NUM_CH = 4;
    localparam int          DEPTH  = 16;
    localparam int          DROP_W = 16;
    localparam logic [31:0] BASE   = 32'hF00000D0;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [31:0]              bus_addr, bus_wdata;
    logic [3:0]               bus_we;
    logic                     char_valid, char_ready;
    logic [7:0]               char_data;
    logic [1:0]               char_ch;
    logic [NUM_CH-1:0]        ch_full, ch_overflow;
    logic [NUM_CH*DROP_W-1:0] drop_cnt;
    logic                     halt_valid, all_empty;
    logic [31:0]              halt_code;

    hfrv_console_sink #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .BASE_ADDR(BASE), .DROP_W(DROP_W)) dut (
        .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
        .char_valid(char_valid), .char_ready(char_ready), .char_data(char_data), .char_ch(char_ch),
        .ch_full(ch_full), .ch_overflow(ch_overflow), .drop_cnt(drop_cnt),
        .halt_valid(halt_valid), .halt_code(halt_code), .all_empty(all_empty)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Behavioural model: one byte queue per channel plus the character currently offered.
    logic [7:0]        q [NUM_CH][$];
    bit                m_valid;
    logic [7:0]        m_data;
    int                m_ch, m_rr;
    logic [NUM_CH-1:0] m_ovf;
    int                m_drop [NUM_CH];
    bit                m_halt;
    logic [31:0]       m_code;

    logic [7:0] log_data [$];
    int         log_ch [$];

    task automatic cmp(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelStep(input bit rst, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] we, input bit rdy);
        int  hit_ch;
        bit  exitw;
        bit  consumed;
        int  g;
        int  c;
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                q[i].delete();
                m_drop[i] = 0;
            end
            m_valid = 0; m_data = 0; m_ch = 0; m_rr = 0; m_ovf = '0; m_halt = 0; m_code = 0;
            return;
        end
        hit_ch = -1;
        exitw  = 0;
        if (we != 0) begin
            for (int i = 0; i < NUM_CH; i++)
                if (a == BASE + 32'(4 * i)) hit_ch = i;
            if (a == BASE + 32'(4 * NUM_CH)) exitw = 1;
        end
        consumed = 0;
        if (m_valid && rdy) begin
            m_rr    = (m_ch + 1) % NUM_CH;
            m_valid = 0;
        end
        if (!m_valid) begin
            g = -1;
            for (int k = 0; k < NUM_CH; k++) begin
                c = (m_rr + k) % NUM_CH;
                if (g < 0 && (q[c].size() > 0 || c == hit_ch)) g = c;
            end
            if (g >= 0) begin
                m_valid = 1;
                m_ch    = g;
                if (q[g].size() > 0) m_data = q[g].pop_front();
                else begin
                    m_data   = d[7:0];
                    consumed = 1;
                end
            end
        end
        if (hit_ch >= 0 && !consumed) begin
            if (q[hit_ch].size() < DEPTH) q[hit_ch].push_back(d[7:0]);
            else begin
                m_ovf[hit_ch] = 1'b1;
                if (m_drop[hit_ch] < (1 << DROP_W) - 1) m_drop[hit_ch]++;
            end
        end
        if (exitw && !m_halt) begin
            m_halt = 1;
            m_code = d;
        end
    endtask

    task automatic checkOutput();
        logic [NUM_CH-1:0]        e_full;
        logic [NUM_CH*DROP_W-1:0] e_drop;
        bit                       e_empty;
        e_empty = !m_valid;
        for (int i = 0; i < NUM_CH; i++) begin
            e_full[i]                 = (q[i].size() == DEPTH);
            e_drop[i*DROP_W +: DROP_W] = DROP_W'(m_drop[i]);
            if (q[i].size() != 0) e_empty = 0;
        end
        cmp("char_valid", char_valid, m_valid);
        if (m_valid) begin
            cmp("char_data", char_data, m_data);
            cmp("char_ch", char_ch, m_ch);
        end
        cmp("ch_full", ch_full, e_full);
        cmp("ch_overflow", ch_overflow, m_ovf);
        cmp("drop_cnt", drop_cnt, e_drop);
        cmp("halt_valid", halt_valid, m_halt);
        cmp("halt_code", halt_code, m_code);
        cmp("all_empty", all_empty, e_empty);
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we,
                                 input bit rdy, input bit rst = 0);
        bus_addr   = a;
        bus_wdata  = d;
        bus_we     = we;
        char_ready = rdy;
        reset      = rst;
        if (char_valid && rdy && !rst) begin
            log_data.push_back(char_data);
            log_ch.push_back(int'(char_ch));
        end
        @(posedge clk);
        modelStep(rst, a, d, we, rdy);
        #1;
        checkOutput();
    endtask

    task automatic storeCh(input int ch, input logic [7:0] b, input bit rdy);
        applyStimulus(BASE + 32'(4 * ch), {24'h0, b}, 4'h1, rdy);
    endtask

    task automatic idle(input bit rdy);
        applyStimulus(32'h0, 32'h0, 4'h0, rdy);
    endtask

    task automatic drainUntilEmpty(input string tag, input int budget);
        int n;
        n = 0;
        while (!all_empty && n < budget) begin
            idle(1);
            n++;
        end
        cmp({tag, "_drained"}, all_empty, 1'b1);
    endtask

    initial begin
        reset = 1; bus_addr = 0; bus_wdata = 0; bus_we = 0; char_ready = 0;
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        cmp("rst_char_data", char_data, 8'h00);
        cmp("rst_char_ch", char_ch, 2'd0);
        cmp("rst_all_empty", all_empty, 1'b1);

        // Single character latency and all_empty recovery.
        storeCh(0, 8'h41, 1);
        cmp("t1_valid", char_valid, 1'b1);
        cmp("t1_data", char_data, 8'h41);
        cmp("t1_ch", char_ch, 2'd0);
        idle(1);
        cmp("t1_valid_drop", char_valid, 1'b0);
        cmp("t1_all_empty", all_empty, 1'b1);

        // Round-robin interleave between ch1 and ch2.
        log_data.delete(); log_ch.delete();
        storeCh(1, "A", 0); storeCh(1, "B", 0); storeCh(2, "x", 0); storeCh(2, "y", 0);
        for (int i = 0; i < 4; i++) idle(1);
        cmp("rr_count", log_data.size(), 4);
        if (log_data.size() == 4) begin
            cmp("rr0", {log_data[0], 8'(log_ch[0])}, {8'h41, 8'd1});
            cmp("rr1", {log_data[1], 8'(log_ch[1])}, {8'h78, 8'd2});
            cmp("rr2", {log_data[2], 8'(log_ch[2])}, {8'h42, 8'd1});
            cmp("rr3", {log_data[3], 8'(log_ch[3])}, {8'h79, 8'd2});
        end
        drainUntilEmpty("rr", 10);

        // Overflow on ch3 while the output stage is occupied by a ch0 character.
        log_data.delete(); log_ch.delete();
        storeCh(0, 8'h30, 0);
        for (int k = 0; k < 20; k++) storeCh(3, 8'(8'h60 + k), 0);
        cmp("ovf_full3", ch_full[3], 1'b1);
        cmp("ovf_sticky3", ch_overflow[3], 1'b1);
        cmp("ovf_drop3", drop_cnt[3*DROP_W +: DROP_W], 16'd4);
        drainUntilEmpty("ovf", 30);
        cmp("ovf_count", log_data.size(), 17);
        if (log_data.size() == 17) begin
            cmp("ovf_first", log_data[0], 8'h30);
            for (int k = 0; k < 16; k++)
                cmp("ovf_order", {log_data[k+1], 8'(log_ch[k+1])}, {8'(8'h60 + k), 8'd3});
        end

        // Backpressure: character held stable for five cycles then accepted once.
        log_data.delete(); log_ch.delete();
        storeCh(2, 8'h55, 0);
        for (int i = 0; i < 5; i++) begin
            idle(0);
            cmp("stall_data", char_data, 8'h55);
            cmp("stall_ch", char_ch, 2'd2);
        end
        idle(1);
        idle(1);
        cmp("stall_once", log_data.size(), 1);

        // Exit register is sticky; queued characters still drain.
        storeCh(0, "a", 0); storeCh(1, "b", 0);
        applyStimulus(BASE + 32'(4 * NUM_CH), 32'h0000002A, 4'hF, 0);
        applyStimulus(BASE + 32'(4 * NUM_CH), 32'h00000001, 4'hF, 0);
        cmp("halt_set", halt_valid, 1'b1);
        cmp("halt_code_kept", halt_code, 32'h2A);
        drainUntilEmpty("halt", 10);

        // Reset mid-operation discards held and queued characters.
        storeCh(0, 8'h10, 0); storeCh(1, 8'h11, 0); storeCh(2, 8'h12, 0); storeCh(3, 8'h13, 0);
        applyStimulus(0, 0, 0, 0, 1);
        cmp("mrst_valid", char_valid, 1'b0);
        cmp("mrst_all_empty", all_empty, 1'b1);
        log_data.delete(); log_ch.delete();
        storeCh(1, 8'h77, 0);
        drainUntilEmpty("mrst", 10);
        cmp("mrst_only_new", log_data.size(), 1);
        if (log_data.size() == 1) cmp("mrst_char", log_data[0], 8'h77);

        // Random traffic across channels, exit register and unmapped addresses.
        for (int n = 0; n < 400; n++) begin
            int sel;
            logic [31:0] a;
            sel = $urandom_range(0, 11);
            a   = (sel < NUM_CH + 1) ? BASE + 32'(4 * sel)
                : (sel == 5) ? BASE - 32'd4 : (sel == 6) ? BASE + 32'd20 : 32'h0;
            applyStimulus(a, $urandom, (sel < 7) ? 4'($urandom_range(1, 15)) : 4'h0,
                          $urandom_range(0, 3) != 0);
        end
        drainUntilEmpty("rand", 100);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
